// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared defaults and request/return types for the I-cache data bank controller
package toy_pack;

  localparam int TP_WAYS       = 4;
  localparam int TP_BANKS      = 2;
  localparam int TP_STARVE_MAX = 4;
  localparam int TP_INDEX_W    = 6;
  localparam int TP_LINE_W     = 512;
  localparam int TP_TXNID_W    = 5;
  localparam int TP_WAY_W      = $clog2(TP_WAYS);

  typedef struct packed {
    logic [TP_WAY_W-1:0]   way;
    logic [TP_INDEX_W-1:0] index;
    logic [TP_TXNID_W-1:0] txnid;
  } icache_data_rd_req_t;

  typedef struct packed {
    logic [TP_WAY_W-1:0]   way;
    logic [TP_INDEX_W-1:0] index;
    logic [TP_TXNID_W-1:0] txnid;
    logic                  fwd;
    logic [TP_LINE_W-1:0]  data;
  } icache_data_fill_req_t;

  typedef struct packed {
    logic                  err;
    logic [TP_TXNID_W-1:0] txnid;
    logic [TP_LINE_W-1:0]  data;
  } icache_data_up_t;

endpackage

// File: rtl/icache_dat_skid_buf.sv
// rtl/icache_dat_skid_buf.sv - 2-entry in-order return buffer, head held stable while stalled
module icache_dat_skid_buf
  import toy_pack::*;
#(
  parameter int DW = TP_LINE_W + TP_TXNID_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_slot0;
  logic [DW-1:0] r_slot1;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;
  logic          w_pop;
  logic          w_push;

  // A push into a full buffer is only legal when the head leaves in the same cycle
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  // Slot storage; cleared on reset so the upstream data/txnid read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (w_push) begin
      if (r_wr_ptr) begin
        r_slot1 <= i_push_data;
      end else begin
        r_slot0 <= i_push_data;
      end
    end
  end

  // Ring pointers and occupancy; push+pop together leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_vld  = (r_cnt != 2'd0);
  assign o_data = r_rd_ptr ? r_slot1 : r_slot0;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/toy_mem_model_bit.sv
// rtl/toy_mem_model_bit.sv - single-port data sub-array with registered read, contents never reset
module toy_mem_model_bit
  import toy_pack::*;
#(
  parameter int AW = TP_INDEX_W + TP_WAY_W,
  parameter int DW = TP_LINE_W / TP_BANKS
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // One access per cycle: either write the addressed word or capture it for the next cycle
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_data_bank_ctrl.sv
// rtl/icache_data_bank_ctrl.sv - I-cache data array controller; per-bank parity when ICACHE_DATA_PARITY_EN is defined
module icache_data_bank_ctrl
  import toy_pack::*;
#(
  parameter int  WAYS       = TP_WAYS,
  parameter int  BANKS      = TP_BANKS,
  parameter int  INDEX_W    = TP_INDEX_W,
  parameter int  LINE_W     = TP_LINE_W,
  parameter int  TXNID_W    = TP_TXNID_W,
  parameter int  STARVE_MAX = TP_STARVE_MAX,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [WAY_W-1:0]   rd_way,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TXNID_W-1:0] rd_txnid,
  input  logic               fill_vld,
  output logic               fill_rdy,
  input  logic [WAY_W-1:0]   fill_way,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TXNID_W-1:0] fill_txnid,
  input  logic               fill_fwd,
  input  logic [LINE_W-1:0]  fill_data,
  output logic               fill_done,
  output logic               up_vld,
  input  logic               up_rdy,
  output logic [LINE_W-1:0]  up_data,
  output logic [TXNID_W-1:0] up_txnid,
  output logic               up_err
);

`ifdef ICACHE_DATA_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BW = LINE_W / BANKS;
  localparam int MW = BW + PB;
  localparam int AW = INDEX_W + WAY_W;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int UW = LINE_W + TXNID_W + PB;

  logic [1:0]         w_occ;
  logic [1:0]         w_credit;
  logic               w_credit_free;
  logic               w_force;
  logic               w_fill_acc;
  logic               w_rd_acc;
  logic [AW-1:0]      w_addr;
  logic [LINE_W-1:0]  w_rd_line;
  logic [UW-1:0]      w_push_data;
  logic [UW-1:0]      w_up_word;
  logic [SW-1:0]      r_starve;
  logic               r_inf_vld;
  logic               r_inf_fill;
  logic [TXNID_W-1:0] r_inf_txnid;
  logic [LINE_W-1:0]  r_fwd_data;
  logic               r_fill_done;
`ifdef ICACHE_DATA_PARITY_EN
  logic [BANKS-1:0]   w_perr;
  logic               w_rd_err;
`endif

  // Credit covers beats already buffered plus the one that lands next cycle,
  // so the 2-entry buffer can never be pushed while full without a pop.
  assign w_credit      = w_occ + {1'b0, r_inf_vld};
  assign w_credit_free = (w_credit < 2'd2);
  assign w_force       = rd_vld && w_credit_free && (r_starve == SW'(STARVE_MAX));
  assign w_fill_acc    = fill_vld && !w_force && (!fill_fwd || w_credit_free);
  assign w_rd_acc      = rd_vld && w_credit_free && (!w_fill_acc || w_force);

  assign fill_rdy  = w_fill_acc;
  assign rd_rdy    = w_rd_acc;
  assign fill_done = r_fill_done;

  // Fill and read are mutually exclusive, so one shared address feeds every bank
  assign w_addr = w_fill_acc ? {fill_index, fill_way} : {rd_index, rd_way};

  // Read starvation counter: counts cycles a pending read lost to a fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_rd_acc) begin
      r_starve <= '0;
    end else if (rd_vld && w_fill_acc && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // In-flight return tracking and fill completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inf_vld   <= 1'b0;
      r_inf_fill  <= 1'b0;
      r_inf_txnid <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_inf_vld   <= w_rd_acc || (w_fill_acc && fill_fwd);
      r_inf_fill  <= w_fill_acc;
      r_inf_txnid <= w_fill_acc ? fill_txnid : rd_txnid;
      r_fill_done <= w_fill_acc;
    end
  end

  // Forwarded fill line is held one cycle to line up with array read latency
  always_ff @(posedge clk) begin
    if (w_fill_acc && fill_fwd) begin
      r_fwd_data <= fill_data;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [MW-1:0] w_wdata;
    logic [MW-1:0] w_rdata;

`ifdef ICACHE_DATA_PARITY_EN
    // Even parity: stored bit makes the bank word XOR to zero
    assign w_wdata   = {^fill_data[b*BW +: BW], fill_data[b*BW +: BW]};
    assign w_perr[b] = (^w_rdata[BW-1:0]) != w_rdata[BW];
`else
    assign w_wdata   = fill_data[b*BW +: BW];
`endif
    assign w_rd_line[b*BW +: BW] = w_rdata[BW-1:0];

    toy_mem_model_bit #(
      .AW (AW),
      .DW (MW)
    ) u_mem (
      .clk     (clk),
      .i_en    (w_fill_acc || w_rd_acc),
      .i_we    (w_fill_acc),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
    );
  end

`ifdef ICACHE_DATA_PARITY_EN
  assign w_rd_err    = |w_perr;
  assign w_push_data = r_inf_fill ? {1'b0, r_inf_txnid, r_fwd_data}
                                  : {w_rd_err, r_inf_txnid, w_rd_line};
  assign up_err      = w_up_word[UW-1];
`else
  assign w_push_data = {r_inf_txnid, (r_inf_fill ? r_fwd_data : w_rd_line)};
  assign up_err      = 1'b0;
`endif

  icache_dat_skid_buf #(
    .DW (UW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inf_vld),
    .i_push_data (w_push_data),
    .i_pop       (up_rdy),
    .o_vld       (up_vld),
    .o_data      (w_up_word),
    .o_cnt       (w_occ)
  );

  assign up_data  = w_up_word[LINE_W-1:0];
  assign up_txnid = w_up_word[LINE_W +: TXNID_W];

endmodule

// File: doc/icache_data_bank_ctrl.md
ICACHE_DATA_BANK_CTRL -- requirements
Module: icache_data_bank_ctrl

Interface
REQ-001 SHALL have parameter WAYS, 4, ways per set (power of 2, >=2); WAY_W = $clog2(WAYS).
REQ-002 SHALL have parameter BANKS, 2, data sub-arrays per line (power of 2, divides LINE_W).
REQ-003 SHALL have parameter INDEX_W, 6, set index width.
REQ-004 SHALL have parameter LINE_W, 512, cacheline width in bits.
REQ-005 SHALL have parameter TXNID_W, 5, transaction id width.
REQ-006 SHALL have parameter STARVE_MAX, 4, consecutive read-blocked cycles before a read is forced.
REQ-007 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset; asynchronous, active-low).
REQ-008 SHALL have ports rd_vld in 1, rd_rdy out 1, rd_way in WAY_W, rd_index in INDEX_W, rd_txnid in TXNID_W (hit read request).
REQ-009 SHALL have ports fill_vld in 1, fill_rdy out 1, fill_way in WAY_W, fill_index in INDEX_W, fill_txnid in TXNID_W, fill_fwd in 1 (also return line upstream), fill_data in LINE_W (linefill write).
REQ-010 SHALL have port fill_done out 1: one-cycle pulse on each accepted fill.
REQ-011 SHALL have ports up_vld out 1, up_rdy in 1, up_data out LINE_W, up_txnid out TXNID_W, up_err out 1 (upstream return channel).

Function
REQ-012 SHALL perform at most one array operation per cycle; all BANKS sub-arrays share address {index, way}, bank b holding bits [(b+1)*LINE_W/BANKS-1 : b*LINE_W/BANKS].
REQ-013 SHALL use credit = buffer occupancy + in-flight returns; "credit free" means credit < 2.
REQ-014 SHALL accept a fill (fill_rdy=1) when fill_vld, no forced read, and (fill_fwd=0 or credit free).
REQ-015 SHALL accept a read (rd_rdy=1) when rd_vld, credit free, and (no fill accepted this cycle or forced read).
REQ-016 SHALL force a read when starve counter == STARVE_MAX and credit free; counter increments per cycle rd_vld=1 and rd_rdy=0 because of a fill, saturates at STARVE_MAX, clears on read accept.
REQ-017 SHALL present read data to the output buffer exactly 1 cycle after read accept; forwarded fill data (registered fill_data) likewise 1 cycle after fill accept.
REQ-018 SHALL return upstream beats strictly in acceptance order via a 2-entry output buffer; up_vld/up_data/up_txnid/up_err stable while up_vld=1 and up_rdy=0.
REQ-019 SHALL pop the buffer on up_vld && up_rdy; push and pop in the same cycle keep occupancy unchanged.
REQ-020 SHALL return a read of a location written in the previous cycle with the new data (write then read, no bypass needed as ops are serial).
REQ-021 SHALL drive up_err=0 always when parity is compiled out.

Reset
REQ-022 SHALL on rst_n=0 clear output buffer, in-flight flag, starve counter, fill_done; up_vld=0, up_err=0, up_data=0, up_txnid=0 immediately.
REQ-023 SHALL drop any in-flight return on reset; array contents are not reset.

Configuration
REQ-024 SHALL with ICACHE_DATA_PARITY_EN defined store one even-parity bit per bank, check on read, set up_err=1 for that beat if any bank mismatches; forwarded fills carry up_err=0.
REQ-025 SHALL without ICACHE_DATA_PARITY_EN use LINE_W/BANKS-bit banks and tie up_err=0.

Structure
REQ-026 SHALL place icache_data_rd_req_t, icache_data_fill_req_t, icache_data_up_t typedefs and default WAYS/BANKS/STARVE_MAX constants in toy_pack.
REQ-027 SHALL instantiate toy_mem_model_bit per bank and one sub-module icache_dat_skid_buf (2-entry ordered output buffer).

Verification
REQ-028 SHALL cover: fill way2 index5 data A, fwd=1 -> fill_done pulse, up beat A txnid matches 1 cycle later; then read way2 index5 -> data A.
REQ-029 SHALL cover: fill_vld held 10 cycles with rd_vld, STARVE_MAX=4 -> read accepted on 5th blocked cycle, fill resumes next cycle.
REQ-030 SHALL cover: up_rdy=0 for 6 cycles, 4 reads offered -> exactly 2 accepted, rd_rdy=0 after, data stable, order preserved on release.
REQ-031 SHALL cover: simultaneous pop and push at occupancy 2 -> no loss, no duplicate.
REQ-032 SHALL cover: rst_n asserted with one read in flight -> up_vld=0 same cycle, no beat after release.
REQ-033 SHALL cover (PARITY_EN): corrupt bank1 bit via backdoor, read -> up_err=1 with that beat only.
